// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and bus-state signals shared by the initiators and pci_bus_arbiter.
// master = initiator/bus side (drives req, frame, irdy); slave = arbiter side.
interface pci_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OWN_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic             frame;
    logic             irdy;
    logic [N_REQ-1:0] gnt;
    logic [OWN_W-1:0] owner;
    logic [1:0]       bus_state;
    logic             timeout;
    logic             proto_err;

    modport master (
        output req, frame, irdy,
        input  gnt, owner, bus_state, timeout, proto_err
    );

    modport slave (
        input  req, frame, irdy,
        output gnt, owner, bus_state, timeout, proto_err
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin bus arbiter with frame/irdy bus-state tracking; optional grant parking (PCI_ARB_PARK_EN).
// Latency: req to registered gnt in 1 cycle; frame/irdy to bus_state in 1 cycle. No backpressure: req is a level held by the initiator.
module pci_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    pci_bus_arbiter_if.slave   bus
);
    localparam int OWN_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(GNT_TIMEOUT + 1);
    localparam logic [1:0]       BUSIDLE  = 2'b01;
    localparam logic [1:0]       BUSBUSY  = 2'b10;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(GNT_TIMEOUT);
    localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_BUSY,
        ST_TURN
    } state_t;

    state_t           state_q,     state_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    logic [OWN_W-1:0] owner_q,     owner_d;
    logic [OWN_W-1:0] ptr_q,       ptr_d;
    logic [TMR_W-1:0] timer_q,     timer_d;
    logic [1:0]       bus_state_q, bus_state_d;
    logic             timeout_q,   timeout_d;
    logic             proto_err_q, proto_err_d;

    logic             win_vld;
    logic [OWN_W-1:0] win_idx;
    logic [OWN_W-1:0] ptr_next;

    function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    // Descending scan so the smallest offset from the pointer is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_idx = OWN_W'(idx);
            end
        end
    end

    assign ptr_next = (owner_q == OWN_LAST) ? '0 : owner_q + OWN_W'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        timeout_d   = 1'b0;
        proto_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
`ifdef PCI_ARB_PARK_EN
                if (gnt_q != '0 && bus.frame) begin
                    state_d = ST_BUSY;
                end else if (win_vld) begin
                    gnt_d   = onehot(win_idx);
                    owner_d = win_idx;
                    state_d = ST_GRANTED;
                end else if (bus.frame) begin
                    gnt_d       = '0;
                    proto_err_d = 1'b1;
                    state_d     = ST_BUSY;
                end else begin
                    gnt_d = onehot(owner_q);
                end
`else
                gnt_d = '0;
                if (win_vld) begin
                    gnt_d   = onehot(win_idx);
                    owner_d = win_idx;
                    state_d = ST_GRANTED;
                end else if (bus.frame) begin
                    proto_err_d = 1'b1;
                    state_d     = ST_BUSY;
                end
`endif
            end
            ST_GRANTED: begin
                timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
                if (bus.frame) begin
                    state_d = ST_BUSY;
                end else if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    ptr_d     = ptr_next;
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Grant is held through the final data phase even if req drops.
                if (!bus.frame && !bus.irdy) begin
                    gnt_d = '0;
                    if (gnt_q != '0) begin
                        ptr_d = ptr_next;
                    end
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        bus_state_d = (state_d == ST_BUSY || state_d == ST_TURN) ? BUSBUSY : BUSIDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            timer_q     <= '0;
            bus_state_q <= BUSIDLE;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            bus_state_q <= bus_state_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.bus_state = bus_state_q;
    assign bus.timeout   = timeout_q;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed test of pci_bus_arbiter: grant latency, round robin, timeout, withdrawal, protocol error, async reset.
// Park-mode checks compile in when PCI_ARB_PARK_EN is defined.
module tb_pci_bus_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pci_bus_arbiter_if #(.N_REQ(4)) bus ();

    pci_bus_arbiter #(
        .N_REQ       (4),
        .GNT_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.req   = 4'b0000;
        bus.frame = 1'b0;
        bus.irdy  = 1'b0;

        #3;
        check("rst_gnt",       32'(bus.gnt),       'h0);
        check("rst_owner",     32'(bus.owner),     'h0);
        check("rst_bus_state", 32'(bus.bus_state), 'h1);
        check("rst_timeout",   32'(bus.timeout),   'h0);
        check("rst_proto_err", 32'(bus.proto_err), 'h0);
        #9 rst = 1'b0;
        step();

        // Single request through a full transaction.
        bus.req = 4'b0100;
        step();
        check("single_gnt",   32'(bus.gnt),       'h4);
        check("single_owner", 32'(bus.owner),     'h2);
        check("single_idle",  32'(bus.bus_state), 'h1);
        bus.frame = 1'b1;
        bus.req   = 4'b0000;
        step();
        check("single_busy",     32'(bus.bus_state), 'h2);
        check("single_gnt_hold", 32'(bus.gnt),       'h4);
        bus.frame = 1'b0;
        bus.irdy  = 1'b1;
        step();
        check("final_phase_busy", 32'(bus.bus_state), 'h2);
        check("final_phase_gnt",  32'(bus.gnt),       'h4);
        bus.irdy = 1'b0;
        step();
        check("end_gnt_drop", 32'(bus.gnt),       'h0);
        check("end_turn_bus", 32'(bus.bus_state), 'h2);
        step();
        check("end_idle_bus", 32'(bus.bus_state), 'h1);

        // Round robin from a fresh pointer.
        pulse_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt",   32'(bus.gnt),   32'(1) << (k % 4));
            check("rr_owner", 32'(bus.owner), 32'(k % 4));
            bus.frame = 1'b1;
            step();
            step();
            step();
            bus.frame = 1'b0;
            step();
            check("rr_turn_gnt", 32'(bus.gnt),       'h0);
            check("rr_turn_bus", 32'(bus.bus_state), 'h2);
            step();
            check("rr_idle_gnt", 32'(bus.gnt),       'h0);
            check("rr_idle_bus", 32'(bus.bus_state), 'h1);
        end

        // Timeout: last owner was 0, pointer now 1.
        bus.req = 4'b0010;
        step();
        check("to_gnt", 32'(bus.gnt), 'h2);
        for (int j = 0; j < 15; j++) begin
            step();
            check("to_gnt_hold", 32'(bus.gnt),     'h2);
            check("to_no_pulse", 32'(bus.timeout), 'h0);
        end
        step();
        check("to_revoke", 32'(bus.gnt),     'h0);
        check("to_pulse",  32'(bus.timeout), 'h1);
        bus.req = 4'b0110;
        step();
        check("to_pulse_one", 32'(bus.timeout), 'h0);
        check("to_next_gnt",  32'(bus.gnt),     'h4);

        // Withdrawal leaves the pointer at 2.
        bus.req = 4'b0010;
        step();
        check("wd_gnt_drop", 32'(bus.gnt), 'h0);
        bus.req = 4'b1110;
        step();
        check("wd_ptr_kept", 32'(bus.gnt), 'h4);
        bus.req = 4'b0000;
        step();
        check("wd2_gnt_drop", 32'(bus.gnt), 'h0);

`ifndef PCI_ARB_PARK_EN
        step();
        check("nopark_gnt", 32'(bus.gnt), 'h0);
        bus.frame = 1'b1;
        step();
        check("perr_pulse", 32'(bus.proto_err), 'h1);
        check("perr_busy",  32'(bus.bus_state), 'h2);
        check("perr_gnt",   32'(bus.gnt),       'h0);
        step();
        check("perr_one",   32'(bus.proto_err), 'h0);
        check("perr_busy2", 32'(bus.bus_state), 'h2);
        bus.frame = 1'b0;
        step();
        check("perr_turn", 32'(bus.bus_state), 'h2);
        step();
        check("perr_idle", 32'(bus.bus_state), 'h1);
        bus.req = 4'b1111;
        step();
        check("perr_ptr_kept", 32'(bus.gnt), 'h4);
        bus.req = 4'b0000;
        step();
`endif

        // Async reset in the middle of a transaction by owner 3.
        bus.req = 4'b1000;
        step();
        check("mid_gnt", 32'(bus.gnt), 'h8);
        bus.frame = 1'b1;
        step();
        check("mid_busy", 32'(bus.bus_state), 'h2);
        #2 rst = 1'b1;
        #1;
        check("arst_gnt",   32'(bus.gnt),       'h0);
        check("arst_bus",   32'(bus.bus_state), 'h1);
        check("arst_owner", 32'(bus.owner),     'h0);
        bus.frame = 1'b0;
        bus.req   = 4'b0000;
        #2 rst = 1'b0;
        step();

`ifdef PCI_ARB_PARK_EN
        bus.req = 4'b1000;
        step();
        bus.req   = 4'b0000;
        bus.frame = 1'b1;
        step();
        bus.frame = 1'b0;
        step();
        step();
        step();
        for (int j = 0; j < 100; j++) begin
            check("park_gnt",     32'(bus.gnt),     'h8);
            check("park_no_tout", 32'(bus.timeout), 'h0);
            step();
        end
        bus.req = 4'b0001;
        step();
        check("park_move", 32'(bus.gnt), 'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Round-robin arbiter and bus-state tracker for the shared frame/irdy bus. Accepts bus requests from up to N_REQ initiators and issues a one-hot registered grant. Follows each granted transaction through frame/irdy and publishes the bus state as BUSIDLE (2'b01) / BUSBUSY (2'b10) for the bus-protocol assertions. Sits between the initiators and the shared bus, beside the first-match idle checker.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GNT_TIMEOUT, 16, max cycles a grant may wait for frame before it is revoked (≥2)
- clk  in  1  bus clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-initiator request, level
- frame  in  1  bus frame, sampled on posedge clk
- irdy  in  1  bus initiator-ready, sampled on posedge clk
- gnt  out  N_REQ  one-hot grant, registered
- owner  out  $clog2(N_REQ)  index of current/last grantee
- bus_state  out  2  2'b01 BUSIDLE, 2'b10 BUSBUSY, registered
- timeout  out  1  one-cycle pulse on grant revocation by timeout
- proto_err  out  1  one-cycle pulse when frame rises with no grant outstanding

## Operation
- Reset (async assert, sync release): state IDLE, gnt=0, owner=0, bus_state=2'b01, timeout=0, proto_err=0, rr pointer=0, timer=0.
- Arbitration: winner = first asserted req scanning upward from pointer, wrapping at N_REQ-1 → 0. Pointer becomes owner+1 (mod N_REQ) whenever a grant ends by completion or timeout. It is unchanged on voluntary withdrawal.
- IDLE: bus_state=01.
  - Any req=1 → gnt[winner]=1, owner=winner, timer=0, go GRANTED.
  - frame=1 with gnt=0 → proto_err pulse, go BUSY with no grant.
- GRANTED: bus_state=01, timer increments each cycle.
  - frame=1 → BUSY.
  - Else req[owner]=0 → gnt=0, back to IDLE.
  - Else timer==GNT_TIMEOUT-1 → gnt=0, timeout pulse, pointer advance, IDLE.
  - Priority when several hold: frame > withdrawal > timeout.
- BUSY: bus_state=10, gnt held even if req drops.
  - frame=0 && irdy=0 → gnt=0, pointer advance (only if a grant existed), go TURNAROUND.
  - frame=0 with irdy=1 stays BUSY (final data phase).
- TURNAROUND: one cycle, bus_state=10, gnt=0, then IDLE. Requests seen in this cycle are arbitrated in IDLE.
- gnt is always one-hot or zero. A grant never changes owner without passing through IDLE.
- Reset mid-transaction immediately drops gnt and returns bus_state to 01.

## Timing
- Request-to-grant: req sampled at edge n in IDLE → gnt visible after edge n (1 cycle).
- Grant-to-BUSY: frame sampled at edge m → bus_state=10 after edge m.
- End of transaction: frame=irdy=0 sampled at edge k → gnt=0 after k. TURNAROUND in k..k+1, IDLE (bus_state=01) after k+1. Earliest next grant after k+2.
- Timeout: grant asserted after edge g. With no frame, revoked and timeout pulsed after edge g+GNT_TIMEOUT.
- Back-to-back same requester: re-granted only if no other req is asserted (fairness).
- timer width $clog2(GNT_TIMEOUT+1). It saturates and never wraps.

## Configuration
- PCI_ARB_PARK_EN defined: in IDLE with no req, gnt parks on owner (last grantee; requester 0 after reset).
  - Park exits with no arbitration delay: a parked owner asserting frame goes directly to BUSY.
  - Another req moves the grant to the arbitration winner on the next edge.
  - A parked grant never times out, and frame from the parked owner is not a proto_err.
- Undefined: gnt=0 whenever IDLE.

## Test plan
- Single request: req=4'b0100 after reset → gnt=4'b0100 one cycle later, owner=2. Then frame=1 → bus_state=10. Then frame=irdy=0 → gnt=0, bus_state=01 two edges later.
- Round robin: req=4'b1111 held, each grant completes a 3-cycle frame → owners 0,1,2,3,0 in order, no gnt overlap, ≥1 TURNAROUND cycle between grants.
- Timeout (GNT_TIMEOUT=16): req=4'b0010, frame never asserted → gnt=0 and timeout=1 for exactly one cycle 16 cycles after grant. The next grant goes to req[2] if asserted.
- Withdrawal and error: req[1] dropped in GRANTED → gnt=0 next edge, pointer unchanged. frame=1 in IDLE with gnt=0 → proto_err one cycle, bus_state=10 until frame=irdy=0.
- Reset mid-BUSY: rst asserted while gnt=4'b1000 and frame=1 → gnt=0, bus_state=01, owner=0 immediately, without waiting for a clock.
- PCI_ARB_PARK_EN: no req after a transaction by owner 3 → gnt=4'b1000 persists, no timeout after 100 cycles. Then req=4'b0001 → gnt=4'b0001 next edge.
